// File: rtl/medidor_frequencia.sv
// medidor_frequencia: frequency meter for the phase-accumulator square-wave generator.
// Aligns on a rising edge of sig_in, counts rises over a gate window of N = 2^(WIDTH+1) clk,
// and reports the recovered tuning word (rises - 1) on a valid/ready port.
// If no rise arrives within 2N clk of arming, it reports 0 with the nosig flag set.
// Optional build macro MEDIDOR_FREQ_AVG_EN: each result is the truncated average of
// four consecutive gate windows. A timed-out window contributes 0 and sets nosig.
module medidor_frequencia #(
  parameter int WIDTH    = 8,
  parameter int SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] meas_data,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             nosig
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } state_t;

  // The arm timeout is 2N-1 and the last window index is N-1. Both are all-ones values.
  localparam logic [WIDTH+1:0] TIMER_LAST = '1;
  localparam logic [WIDTH:0]   WIN_LAST   = '1;

  state_t             state;
  logic [SYNC_STG-1:0] sync_q;
  logic               s_d;
  logic               rise;
  logic [WIDTH+1:0]   timer;
  logic [WIDTH:0]     win_cnt;
  logic [WIDTH:0]     edge_cnt;
  logic [WIDTH:0]     gate_total;
  logic [WIDTH-1:0]   win_res;

`ifdef MEDIDOR_FREQ_AVG_EN
  logic [WIDTH+1:0]   avg_acc;
  logic [1:0]         avg_idx;
  logic               avg_nosig;
  logic [WIDTH+1:0]   avg_sum;
`endif

  // Metastability guard for the asynchronous input. The oldest flop feeds edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STG-2:0], sig_in};
  end

  // Delayed copy of the synchronized level, used to detect rising edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_d <= 1'b0;
    else      s_d <= sync_q[SYNC_STG-1];
  end

  assign rise = sync_q[SYNC_STG-1] & ~s_d;

  // Rise count including the current cycle; the window result is that count minus one, saturating at 0.
  always_comb begin
    gate_total = edge_cnt + {{WIDTH{1'b0}}, rise};
    win_res    = '0;
    if (gate_total != '0) win_res = gate_total[WIDTH-1:0] - WIDTH'(1);
  end

`ifdef MEDIDOR_FREQ_AVG_EN
  // Running sum of the finished windows plus the window that is closing now.
  always_comb avg_sum = avg_acc + {2'b00, win_res};
`endif

  // Measurement FSM: arm on an alignment edge, gate for N cycles, then hold the result until it is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      meas_data  <= '0;
      meas_valid <= 1'b0;
      nosig      <= 1'b0;
`ifdef MEDIDOR_FREQ_AVG_EN
      avg_acc    <= '0;
      avg_idx    <= '0;
      avg_nosig  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= ARM;
            timer <= '0;
          end
        end

        ARM: begin
          if (!enable) begin
            state <= IDLE;
`ifdef MEDIDOR_FREQ_AVG_EN
            avg_acc   <= '0;
            avg_idx   <= '0;
            avg_nosig <= 1'b0;
`endif
          end else if (rise) begin
            state    <= GATE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else if (timer == TIMER_LAST) begin
`ifdef MEDIDOR_FREQ_AVG_EN
            if (avg_idx == 2'd3) begin
              state      <= DONE;
              meas_valid <= 1'b1;
              meas_data  <= avg_acc[WIDTH+1:2];
              nosig      <= 1'b1;
              avg_acc    <= '0;
              avg_idx    <= '0;
              avg_nosig  <= 1'b0;
            end else begin
              avg_idx   <= avg_idx + 2'd1;
              avg_nosig <= 1'b1;
              timer     <= '0;
            end
`else
            state      <= DONE;
            meas_valid <= 1'b1;
            meas_data  <= '0;
            nosig      <= 1'b1;
`endif
          end else begin
            timer <= timer + (WIDTH+2)'(1);
          end
        end

        GATE: begin
          if (!enable) begin
            state <= IDLE;
`ifdef MEDIDOR_FREQ_AVG_EN
            avg_acc   <= '0;
            avg_idx   <= '0;
            avg_nosig <= 1'b0;
`endif
          end else if (win_cnt == WIN_LAST) begin
`ifdef MEDIDOR_FREQ_AVG_EN
            if (avg_idx == 2'd3) begin
              state      <= DONE;
              meas_valid <= 1'b1;
              meas_data  <= avg_sum[WIDTH+1:2];
              nosig      <= avg_nosig;
              avg_acc    <= '0;
              avg_idx    <= '0;
              avg_nosig  <= 1'b0;
            end else begin
              state   <= ARM;
              timer   <= '0;
              avg_acc <= avg_sum;
              avg_idx <= avg_idx + 2'd1;
            end
`else
            state      <= DONE;
            meas_valid <= 1'b1;
            meas_data  <= win_res;
            nosig      <= 1'b0;
`endif
          end else begin
            win_cnt  <= win_cnt + (WIDTH+1)'(1);
            edge_cnt <= gate_total;
          end
        end

        DONE: begin
          if (meas_ready) begin
            meas_valid <= 1'b0;
            timer      <= '0;
            state      <= enable ? ARM : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_medidor_frequencia.sv
// tb_medidor_frequencia: drives the meter from a phase-accumulator generator model and
// predicts each result from the count of rising edges seen on sig_in over the last N cycles.
module tb_medidor_frequencia;

  localparam int WIDTH    = 8;
  localparam int SYNC_STG = 2;
  localparam int N        = 1 << (WIDTH + 1);

  logic             clk        = 1'b0;
  logic             rst        = 1'b0;
  logic             enable     = 1'b0;
  logic             meas_ready = 1'b0;
  logic             sig_in;
  logic [WIDTH-1:0] meas_data;
  logic             meas_valid;
  logic             nosig;

  logic             gen_on   = 1'b0;
  logic [WIDTH-1:0] gen_word = '0;
  logic [WIDTH:0]   gen_acc  = '0;

  int checks   = 0;
  int errors   = 0;
  int results  = 0;
  int accepts  = 0;
  bit just_accepted     = 1'b0;
  bit no_valid_expected = 1'b0;
  bit sig_hist[$];

  medidor_frequencia #(.WIDTH(WIDTH), .SYNC_STG(SYNC_STG)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sig_in     (sig_in),
    .meas_data  (meas_data),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .nosig      (nosig)
  );

  always #5 clk = ~clk;

  // Square-wave generator: phase accumulator stepping by word+1; its MSB is the output.
  always @(posedge clk) begin
    if (!gen_on) gen_acc <= '0;
    else         gen_acc <= gen_acc + {1'b0, gen_word} + 1'b1;
  end
  assign sig_in = gen_acc[WIDTH];

  // Count handshakes as they happen at the clock edge.
  always @(posedge clk) begin
    just_accepted = rst && meas_valid && meas_ready;
    if (just_accepted) accepts++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit rdy, input logic [WIDTH-1:0] word, input bit on);
    @(negedge clk);
    enable     = en;
    meas_ready = rdy;
    gen_word   = word;
    gen_on     = on;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitValid(input int max_cyc, input string name, output int cyc);
    cyc = 0;
    while (!meas_valid && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(name, meas_valid, 1);
  endtask

  task automatic nextResult(input string name);
    int c;
    c = 0;
    while (meas_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    waitValid(3 * N, name, c);
  endtask

  // Stall on a result, retune the generator, then release so the next window sees only the new word.
  task automatic switchWord(input logic [WIDTH-1:0] word);
    int c;
    applyStimulus(1'b1, 1'b0, gen_word, 1'b1);
    waitValid(3 * N, "stall_before_switch", c);
    applyStimulus(1'b1, 1'b0, word, 1'b1);
    waitCycles(20);
    applyStimulus(1'b1, 1'b1, word, 1'b1);
  endtask

  // Model and per-cycle compare: a result equals (rises in the last N cycles) - 1, and nosig means zero rises.
  initial begin : monitor
    bit               prev_valid;
    logic [WIDTH-1:0] exp_data;
    bit               exp_nosig;
    int               rises;
    prev_valid = 1'b0;
    exp_data   = '0;
    exp_nosig  = 1'b0;
    forever begin
      @(negedge clk);
      sig_hist.push_back(sig_in);
      if (sig_hist.size() > N + 1) void'(sig_hist.pop_front());
      if (!rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (just_accepted) checkOutput("valid_drop_after_accept", meas_valid, 0);
      if (no_valid_expected) checkOutput("no_valid_while_aborted", meas_valid, 0);
      if (meas_valid && !prev_valid) begin
        rises = 0;
        for (int i = 1; i < sig_hist.size(); i++)
          if (!sig_hist[i-1] && sig_hist[i]) rises++;
        exp_nosig = (rises == 0);
        exp_data  = (rises == 0) ? '0 : WIDTH'(rises - 1);
        results++;
      end
      if (meas_valid) begin
        checkOutput("model_data", meas_data, exp_data);
        checkOutput("model_nosig", nosig, exp_nosig);
      end
      prev_valid = meas_valid;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before the end of the sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cyc;
    int acc_before;
    int res_before;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", meas_valid, 0);
    checkOutput("reset_data", meas_data, 0);
    checkOutput("reset_nosig", nosig, 0);
    rst = 1'b1;

    // T1: word 0, first result within the latency bound
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    waitCycles(20);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
    waitValid(2 * N + SYNC_STG + 4, "t1_first_valid_latency", cyc);
    checkOutput("t1_data", meas_data, 8'h00);
    checkOutput("t1_nosig", nosig, 0);
    nextResult("t1_second_valid");
    checkOutput("t1_data2", meas_data, 8'h00);

    // T2: extreme and mid-range words
    switchWord(8'hFF);
    nextResult("t2_ff_valid_a");
    checkOutput("t2_ff_a", meas_data, 8'hFF);
    nextResult("t2_ff_valid_b");
    checkOutput("t2_ff_b", meas_data, 8'hFF);
    switchWord(8'h64);
    nextResult("t2_64_valid_a");
    checkOutput("t2_64_a", meas_data, 8'h64);
    nextResult("t2_64_valid_b");
    checkOutput("t2_64_b", meas_data, 8'h64);

    // T3: no signal leads to a timeout result
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    waitCycles(10);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    waitCycles(10);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
    waitValid(2 * N + 8, "t3_valid", cyc);
    checkOutput("t3_timeout_window", (cyc >= 2 * N && cyc <= 2 * N + 2), 1);
    checkOutput("t3_data", meas_data, 8'h00);
    checkOutput("t3_nosig", nosig, 1);

    // T4: long backpressure stall with a word change
    applyStimulus(1'b0, 1'b0, 8'h10, 1'b1);
    waitCycles(10);
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b1);
    waitValid(3 * N, "t4_first_valid", cyc);
    #1;
    checkOutput("t4_first", meas_data, 8'h10);
    acc_before = accepts;
    waitCycles(100);
    applyStimulus(1'b1, 1'b0, 8'h20, 1'b1);
    waitCycles(2900);
    checkOutput("t4_held_valid", meas_valid, 1);
    checkOutput("t4_held_data", meas_data, 8'h10);
    checkOutput("t4_no_accept_in_stall", accepts, acc_before);
    applyStimulus(1'b1, 1'b1, 8'h20, 1'b1);
    nextResult("t4_second_valid");
    #1;
    checkOutput("t4_second", meas_data, 8'h20);
    checkOutput("t4_single_accept", accepts, acc_before + 1);
    checkOutput("t4_handshake_balance", results, accepts + 1);

    // T5: enable dropped inside the gate window, then re-enabled
    applyStimulus(1'b0, 1'b1, 8'h64, 1'b1);
    waitCycles(20);
    applyStimulus(1'b1, 1'b1, 8'h64, 1'b1);
    waitCycles(105);
    res_before = results;
    applyStimulus(1'b0, 1'b1, 8'h64, 1'b1);
    no_valid_expected = 1'b1;
    waitCycles(1200);
    no_valid_expected = 1'b0;
    checkOutput("t5_no_result_after_abort", results, res_before);
    applyStimulus(1'b1, 1'b1, 8'h64, 1'b1);
    waitValid(3 * N, "t5_reenable_valid", cyc);
    checkOutput("t5_reenable_data", meas_data, 8'h64);

    // Reset pulsed mid-window: outputs clear without waiting for a clock edge
    waitCycles(150);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_valid", meas_valid, 0);
    checkOutput("async_reset_data", meas_data, 0);
    checkOutput("async_reset_nosig", nosig, 0);
    @(negedge clk);
    rst = 1'b1;
    waitValid(3 * N, "post_reset_valid", cyc);
    checkOutput("post_reset_data", meas_data, 8'h64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
